// File: rtl/ascii_arb_pkg.sv
// Shared types and defaults for the ascii_master_controller write-port arbiter.
package ascii_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StGrant,
    StRelease
  } state_t;

  localparam int unsigned ADDR_W_DEF     = 13;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned ADDR_LIMIT_DEF = 80 * 60;

endpackage

// File: rtl/ascii_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int unsigned cand;
    cand   = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr) + off) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ascii_write_arbiter.sv
// Round-robin burst arbiter for the ascii_master_controller write port.
// Define BURST_LIMIT_EN to cap each grant at BURST_MAX accepted beats.
module ascii_write_arbiter
  import ascii_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int unsigned BURST_MAX  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    wr_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  input  logic [NUM_REQ-1:0]    wr_last,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    wr_ready,
  output logic                  ascii_write_en,
  output logic [ADDR_W-1:0]     ascii_write_address,
  output logic [DATA_W-1:0]     ascii_input,
  output logic                  busy,
  output logic [15:0]           drop_count
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q;
  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    gidx_q;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_valid;

  logic               beat_acc;
  logic [ADDR_W-1:0]  beat_addr;
  logic [DATA_W-1:0]  beat_data;
  logic               beat_legal;
  logic               burst_done;
  logic               grant_exit;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IdxW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign wr_ready = (state_q == StGrant) ? gnt : '0;
  assign busy     = (state_q != StIdle);

`ifdef BURST_LIMIT_EN
  localparam int unsigned CntW = $clog2(BURST_MAX + 1);
  logic [CntW-1:0] burst_cnt_q;
  assign burst_done = (burst_cnt_q == CntW'(BURST_MAX - 1));
`else
  assign burst_done = 1'b0;
`endif

  always_comb begin
    beat_acc   = |(wr_valid & wr_ready);
    beat_addr  = wr_addr[gidx_q*ADDR_W +: ADDR_W];
    beat_data  = wr_data[gidx_q*DATA_W +: DATA_W];
    beat_legal = (32'(beat_addr) < ADDR_LIMIT);
    // A beat on the same cycle as a req drop is still written; only one release follows.
    grant_exit = (beat_acc && (wr_last[gidx_q] || burst_done)) || !req[gidx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= StIdle;
      ptr_q               <= '0;
      gidx_q              <= '0;
      gnt                 <= '0;
      ascii_write_en      <= 1'b0;
      ascii_write_address <= '0;
      ascii_input         <= '0;
      drop_count          <= '0;
`ifdef BURST_LIMIT_EN
      burst_cnt_q         <= '0;
`endif
    end else begin
      ascii_write_en <= 1'b0;
      if (beat_acc) begin
        if (beat_legal) begin
          ascii_write_en      <= 1'b1;
          ascii_write_address <= beat_addr;
          ascii_input         <= beat_data;
        end else if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
`ifdef BURST_LIMIT_EN
        burst_cnt_q <= burst_cnt_q + 1'b1;
`endif
      end

      case (state_q)
        StIdle: begin
          if (|req) state_q <= StArb;
        end
        StArb: begin
`ifdef BURST_LIMIT_EN
          burst_cnt_q <= '0;
`endif
          if (pick_valid) begin
            gnt     <= pick_onehot;
            gidx_q  <= pick_idx;
            state_q <= StGrant;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (grant_exit) begin
            gnt     <= '0;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          ptr_q   <= (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
          state_q <= (|req) ? StArb : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_write_arbiter.sv
// Directed scoreboard bench for ascii_write_arbiter (2 requesters).
module tb_ascii_write_arbiter;

`ifdef BURST_LIMIT_EN
  localparam int unsigned TbBurst = 4;
`else
  localparam int unsigned TbBurst = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  wr_valid;
  logic [25:0] wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_last;
  logic [1:0]  gnt;
  logic [1:0]  wr_ready;
  logic        ascii_write_en;
  logic [12:0] ascii_write_address;
  logic [31:0] ascii_input;
  logic        busy;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;
  logic [44:0] sb[$];

  always #5 clk = ~clk;

  ascii_write_arbiter #(
    .NUM_REQ   (2),
    .ADDR_W    (13),
    .DATA_W    (32),
    .ADDR_LIMIT(4800),
    .BURST_MAX (TbBurst)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req                (req),
    .wr_valid           (wr_valid),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_last            (wr_last),
    .gnt                (gnt),
    .wr_ready           (wr_ready),
    .ascii_write_en     (ascii_write_en),
    .ascii_write_address(ascii_write_address),
    .ascii_input        (ascii_input),
    .busy               (busy),
    .drop_count         (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding legal beat.
  always @(negedge clk) begin
    logic [44:0] exp;
    if (ascii_write_en) begin
      exp = (sb.size() != 0) ? sb.pop_front() : 45'bx;
      check("write", {19'd0, ascii_write_address, ascii_input}, {19'd0, exp});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    int n = 0;
    while (gnt == 2'b00 && n < 20) begin
      step(1);
      n++;
    end
    check(tag, gnt, exp);
  endtask

  // Drive one beat from requester r once it is ready; new_req is applied on the same cycle.
  task automatic beat(input int r, input logic [12:0] a, input logic [31:0] d, input logic l,
                      input logic [1:0] new_req);
    int n = 0;
    while (!wr_ready[r] && n < 50) begin
      step(1);
      n++;
    end
    check("ready_wait", wr_ready[r], 1);
    if (wr_ready[r]) begin
      wr_valid[r]          = 1'b1;
      wr_addr[r*13 +: 13]  = a;
      wr_data[r*32 +: 32]  = d;
      wr_last[r]           = l;
      req                  = new_req;
      if (a < 13'd4800) sb.push_back({a, d});
      step(1);
      wr_valid = 2'b00;
      wr_last  = 2'b00;
    end
  endtask

  initial begin
    int exp_ptr;
    int g;
    rst = 1'b1; req = 2'b00; wr_valid = 2'b00; wr_addr = '0; wr_data = '0; wr_last = 2'b00;
    step(2);
    check("rst_gnt", gnt, 0);
    check("rst_en", ascii_write_en, 0);
    check("rst_addr", ascii_write_address, 0);
    check("rst_data", ascii_input, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single requester, 3-beat burst; requester 1's stray valid must be ignored.
    req = 2'b01;
    step(1);
    check("arb_gnt_zero", gnt, 0);
    check("arb_busy", busy, 1);
    step(1);
    check("gnt_latency", gnt, 2'b01);
    check("ready_nongranted", wr_ready[1], 0);
    wr_addr[13 +: 13] = 13'd7;
    beat(0, 13'd0, 32'h41FFFFFF, 1'b0, 2'b01);
    wr_valid[1] = 1'b1;
    beat(0, 13'd1, 32'h41FFFFFF, 1'b0, 2'b01);
    wr_valid[1] = 1'b1;
    beat(0, 13'd2, 32'h41FFFFFF, 1'b1, 2'b00);
    check("release_gnt", gnt, 0);
    check("release_busy", busy, 1);
    step(1);
    check("idle_busy", busy, 0);

    // Both requesting: grants alternate starting from the post-release pointer (1).
    req = 2'b11;
    exp_ptr = 1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt("rr_gnt", 2'(1 << exp_ptr));
      g = (gnt == 2'b10) ? 1 : 0;
      beat(g, 13'(200 + i), 32'(32'h52000000 + i), 1'b1, (i == 3) ? 2'b00 : 2'b11);
      exp_ptr = (g + 1) % 2;
    end
    step(3);
    check("rr_idle", busy, 0);

    // Address filter: 4800 dropped, 4799 written.
    req = 2'b01;
    wait_gnt("flt_gnt", 2'b01);
    beat(0, 13'd4800, 32'h58000001, 1'b0, 2'b01);
    beat(0, 13'd4799, 32'h59000002, 1'b0, 2'b01);
    req = 2'b00;
    step(3);
    check("drop_one", drop_count, 1);
    check("addr_hold", ascii_write_address, 13'd4799);
    req = 2'b01;
`ifdef BURST_LIMIT_EN
    for (int i = 0; i < 20; i++) beat(0, 13'(4800 + i), 32'h5A000000, 1'b0, 2'b01);
    req = 2'b00;
    step(3);
    check("drop_count20", drop_count, 21);
`else
    for (int i = 0; i < 65536; i++) beat(0, 13'(4800 + (i % 3392)), 32'h5A000000, 1'b0, 2'b01);
    req = 2'b00;
    step(3);
    check("drop_sat", drop_count, 16'hFFFF);
`endif
    check("addr_hold2", ascii_write_address, 13'd4799);
    check("data_hold", ascii_input, 32'h59000002);

    // Requester 0 drops req with a valid beat; beat written, then requester 1 granted.
    req = 2'b01;
    wait_gnt("drop_gnt0", 2'b01);
    req = 2'b11;
    beat(0, 13'd10, 32'h61000010, 1'b0, 2'b11);
    beat(0, 13'd11, 32'h62000011, 1'b0, 2'b10);
    check("drop_release", gnt, 0);
    wait_gnt("drop_gnt1", 2'b10);
    beat(1, 13'd12, 32'h63000012, 1'b1, 2'b00);
    step(3);

    // Reset on the cycle a beat would be accepted.
    req = 2'b01;
    wait_gnt("rstb_gnt", 2'b01);
    wr_valid = 2'b01; wr_addr[0 +: 13] = 13'd20; wr_data[0 +: 32] = 32'h64000020;
    #2 rst = 1'b1;
    step(1);
    check("rstb_en", ascii_write_en, 0);
    check("rstb_gnt0", gnt, 0);
    check("rstb_drop", drop_count, 0);
    wr_valid = 2'b00; req = 2'b00;
    rst = 1'b0;
    step(1);

    // Burst cap (pointer is 0 after reset).
    req = 2'b11;
    wait_gnt("burst_gnt0", 2'b01);
`ifdef BURST_LIMIT_EN
    for (int i = 0; i < 4; i++) beat(0, 13'(100 + i), 32'(32'h70000000 + i), 1'b0, 2'b11);
    check("burst_release", gnt, 0);
    wait_gnt("burst_gnt1", 2'b10);
    beat(1, 13'd300, 32'h71000300, 1'b1, 2'b01);
    wait_gnt("burst_gnt0b", 2'b01);
    beat(0, 13'd104, 32'h70000004, 1'b0, 2'b01);
    beat(0, 13'd105, 32'h70000005, 1'b1, 2'b00);
`else
    for (int i = 0; i < 5; i++) begin
      beat(0, 13'(100 + i), 32'(32'h70000000 + i), 1'b0, 2'b11);
      check("burst_hold", gnt, 2'b01);
    end
    beat(0, 13'd105, 32'h70000005, 1'b1, 2'b10);
    wait_gnt("burst_gnt1", 2'b10);
    beat(1, 13'd300, 32'h71000300, 1'b1, 2'b00);
`endif
    step(4);
    check("final_idle", busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
